rl11_dma: RTL and testbench

//  Unibus NPR data mover for the RL01/2 disk interface. The controller loads a start bus address, a word count and a direction, then pulses start.
//  The block then performs one Unibus data cycle per NPR grant, moving words between a local sector buffer and PDP memory.
//  On completion it reports the final address, the residual count and any non-existent-memory (NXM) error, so the controller can update RLBA/RLMP/RLCS.

---
 rtl/rl11_dma_if.sv | 27 ++
 rtl/rl11_dma.sv | 177 +++++++++++++++++
 tb/tb_rl11_dma.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rl11_dma_if.sv
// Unibus signal bundle between the RL11 NPR data mover and the bus.
// The master side is the DMA engine. The slave side is the bus, arbiter or memory.
`timescale 1ns/1ps
interface rl11_dma_if;
  logic        init_in_h;
  logic        npr_out_h;
  logic        npg_in_h;
  logic        sack_out_h;
  logic        bbsy_in_h;
  logic        bbsy_out_h;
  logic        ssyn_in_h;
  logic [15:0] d_in_h;
  logic        msyn_out_h;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h;

  modport master (
    input  init_in_h, npg_in_h, bbsy_in_h, ssyn_in_h, d_in_h,
    output npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h
  );

  modport slave (
    output init_in_h, npg_in_h, bbsy_in_h, ssyn_in_h, d_in_h,
    input  npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h
  );
endinterface

// File: rtl/rl11_dma.sv
// RL11 Unibus NPR data mover. It moves one word per bus grant between the local
// sector buffer and PDP memory, and reports the final address, the residual count and NXM.
`timescale 1ns/1ps
module rl11_dma #(
  parameter int unsigned SETTLE  = 15,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned BUFAW   = 8
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic             dir_write,
  input  logic [17:0]      start_ba,
  input  logic [15:0]      start_wc,
  output logic             busy,
  output logic             done,
  output logic             nxm,
  output logic [17:0]      cur_ba,
  output logic [15:0]      cur_wc,
  output logic [BUFAW-1:0] buf_addr,
  output logic [15:0]      buf_wdata,
  output logic             buf_we,
  input  logic [15:0]      buf_rdata,
  rl11_dma_if.master       bus
);

  localparam int unsigned CntMax = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [3:0] {
    StIdle, StReq, StAck, StMast, StFetch, StSetup, StWait, StDskw, StNext, StFin
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [17:0]      ba_q, ba_d;
  logic [15:0]      wc_q, wc_d;
  logic [BUFAW-1:0] addr_q, addr_d;
  logic             nxm_q, nxm_d;
  logic [15:0]      dout_q, dout_d;
  logic             we_q, we_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             drive;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ba_q    <= '0;
      wc_q    <= '0;
      addr_q  <= '0;
      nxm_q   <= 1'b0;
      dout_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ba_q    <= ba_d;
      wc_q    <= wc_d;
      addr_q  <= addr_d;
      nxm_q   <= nxm_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ba_d    = ba_q;
    wc_d    = wc_q;
    addr_d  = addr_q;
    nxm_d   = nxm_q;
    dout_d  = dout_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ba_d    = start_ba & ~18'd1;
          wc_d    = start_wc;
          dir_d   = dir_write;
          addr_d  = '0;
          nxm_d   = 1'b0;
          state_d = (start_wc == 16'd0) ? StFin : StReq;
        end
      end
      StReq:   if (bus.npg_in_h) state_d = StAck;
      StAck: begin
        if (!bus.npg_in_h && !bus.bbsy_in_h && !bus.ssyn_in_h) state_d = StMast;
      end
      StMast: begin
        cnt_d   = '0;
        state_d = dir_q ? StSetup : StFetch;
      end
      StFetch: begin
        dout_d  = buf_rdata;
        state_d = StSetup;
      end
      StSetup: begin
        if (cnt_q == CntW'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWait: begin
        if (bus.ssyn_in_h) begin
          if (dir_q) begin
            we_d    = 1'b1;
            wdata_d = bus.d_in_h;
          end
          state_d = StDskw;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          nxm_d   = 1'b1;
          state_d = StDskw;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDskw:  if (!bus.ssyn_in_h) state_d = StNext;
      StNext: begin
        dout_d = '0;
        if (nxm_q) begin
          state_d = StFin;
        end else begin
          ba_d    = ba_q + 18'd2;
          wc_d    = wc_q - 16'd1;
          addr_d  = addr_q + BUFAW'(1);
          state_d = (wc_q == 16'd1) ? StFin : StReq;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // INIT behaves as a synchronous reset and abandons any transfer silently
    if (bus.init_in_h) begin
      state_d = StIdle;
      cnt_d   = '0;
      dir_d   = 1'b0;
      ba_d    = '0;
      wc_d    = '0;
      addr_d  = '0;
      nxm_d   = 1'b0;
      dout_d  = '0;
      we_d    = 1'b0;
      wdata_d = '0;
    end
  end

  // Address/control stay up through DSKW so the slave sees them steady while SSYN drops
  assign drive          = state_q inside {StSetup, StWait, StDskw};
  assign bus.npr_out_h  = (state_q == StReq);
  assign bus.sack_out_h = (state_q == StAck);
  assign bus.bbsy_out_h = state_q inside {StMast, StFetch, StSetup, StWait, StDskw};
  assign bus.msyn_out_h = (state_q == StWait);
  assign bus.a_out_h    = drive ? ba_q : 18'd0;
  assign bus.c_out_h    = (drive && !dir_q) ? 2'b10 : 2'b00;
  assign bus.d_out_h    = dout_q;

  assign busy      = (state_q != StIdle) && (state_q != StFin);
  assign done      = (state_q == StFin);
  assign nxm       = nxm_q;
  assign cur_ba    = ba_q;
  assign cur_wc    = wc_q;
  assign buf_addr  = addr_q;
  assign buf_wdata = wdata_q;
  assign buf_we    = we_q;

endmodule

// File: tb/tb_rl11_dma.sv
// Bench for rl11_dma: an arbiter, a memory slave and a sector buffer around the DUT.
// A transfer-level model predicts every bus cycle, buffer write and final status.
`timescale 1ns/1ps
module tb_rl11_dma;
  localparam int unsigned SETTLE  = 15;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned BUFAW   = 8;
  localparam int unsigned AckDly  = 2;  // slave raises SSYN so MSYN stays high AckDly+2 cycles

  logic CLOCK = 1'b0;
  logic RESET_N = 1'b0;
  logic start = 1'b0;
  logic dir_write = 1'b0;
  logic [17:0] start_ba = '0;
  logic [15:0] start_wc = '0;
  logic busy, done, nxm, buf_we;
  logic [17:0] cur_ba;
  logic [15:0] cur_wc, buf_wdata, buf_rdata;
  logic [BUFAW-1:0] buf_addr;

  rl11_dma_if bus ();

  rl11_dma #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .BUFAW(BUFAW)) u_dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .start(start), .dir_write(dir_write),
    .start_ba(start_ba), .start_wc(start_wc), .busy(busy), .done(done), .nxm(nxm),
    .cur_ba(cur_ba), .cur_wc(cur_wc), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .buf_we(buf_we), .buf_rdata(buf_rdata), .bus(bus)
  );

  always #5 CLOCK = ~CLOCK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sector buffer: source contents set by the bench, DUT writes captured separately
  logic [15:0] bsrc [256];
  logic [15:0] bdst [256];
  always @(posedge CLOCK) begin
    buf_rdata <= bsrc[buf_addr];
    if (buf_we) bdst[buf_addr] <= buf_wdata;
  end

  bit grant_en = 1'b1;
  always @(posedge CLOCK) bus.npg_in_h <= grant_en && bus.npr_out_h && !bus.sack_out_h;
  assign bus.bbsy_in_h = bus.bbsy_out_h;

  logic [17:0] dead_addr = 18'h3ffff;
  logic [15:0] rmem [logic [17:0]];
  int unsigned scnt = 0;
  always @(posedge CLOCK) begin
    if (!bus.msyn_out_h) begin
      bus.ssyn_in_h <= 1'b0;
      scnt <= 0;
    end else if (bus.a_out_h != dead_addr) begin
      if (scnt == AckDly) begin
        bus.ssyn_in_h <= 1'b1;
        bus.d_in_h    <= rmem[bus.a_out_h];
      end else begin
        scnt <= scnt + 1;
      end
    end
  end

  typedef struct {logic [17:0] a; logic [1:0] c; logic [15:0] d; int hi;} cyc_t;
  typedef struct {logic [7:0] idx; logic [15:0] d;} wr_t;
  cyc_t exp_q[$];
  wr_t  expw_q[$];
  logic [17:0] exp_ba;
  logic [15:0] exp_wc;
  logic        exp_nxm;
  bit          model_active = 1'b0;
  int          done_cnt = 0;
  int          npr_cnt = 0;
  logic [17:0] seen_a[$];

  task automatic plan(input logic dir, input logic [17:0] ba, input logic [15:0] wc);
    logic [17:0] a;
    exp_q.delete();
    expw_q.delete();
    a = ba & ~18'd1;
    exp_nxm = 1'b0;
    exp_wc = wc;
    for (int i = 0; i < int'(wc); i++) begin
      cyc_t cy;
      cy.a = a;
      cy.c = dir ? 2'b00 : 2'b10;
      cy.d = dir ? 16'd0 : bsrc[i % 256];
      if (a == dead_addr) begin
        cy.hi = TIMEOUT;
        exp_q.push_back(cy);
        exp_nxm = 1'b1;
        break;
      end
      cy.hi = AckDly + 2;
      exp_q.push_back(cy);
      if (dir) expw_q.push_back('{idx: 8'(i), d: rmem[a]});
      a = a + 18'd2;
      exp_wc = exp_wc - 16'd1;
    end
    exp_ba = a;
    model_active = 1'b1;
  endtask

  initial begin : compare
    logic [35:0] nowbus, pbus;
    logic pm;
    int hi, run;
    cyc_t cur;
    wr_t w;
    pbus = '0; pm = 1'b0; hi = 0; run = 0;
    cur = '{a: '0, c: '0, d: '0, hi: 0};
    forever begin
      @(negedge CLOCK);
      nowbus = {bus.a_out_h, bus.c_out_h, bus.d_out_h};
      run = (nowbus == pbus) ? run + 1 : 1;
      check("bbsy_while_npg", bus.bbsy_out_h && !bus.sack_out_h && bus.npg_in_h, 0);
      if (bus.npr_out_h) npr_cnt++;
      if (model_active) begin
        if (bus.msyn_out_h && !pm) begin
          check("settle_cycles", run, SETTLE + 1);
          seen_a.push_back(bus.a_out_h);
          if (exp_q.size() == 0) check("unexpected_cycle", 1, 0);
          else begin
            cur = exp_q.pop_front();
            check("cycle_abus", nowbus, {cur.a, cur.c, cur.d});
          end
          hi = 1;
        end else if (bus.msyn_out_h) begin
          check("abus_stable_msyn", nowbus, pbus);
          hi++;
        end else if (pm) begin
          check("msyn_width", hi, cur.hi);
          check("abus_held_dskw", nowbus, pbus);
        end
        if (buf_we) begin
          if (expw_q.size() == 0) check("unexpected_write", 1, 0);
          else begin
            w = expw_q.pop_front();
            check("buf_write", {buf_addr, buf_wdata}, {w.idx, w.d});
          end
        end
      end
      if (done) begin
        if (!model_active) check("unexpected_done", 1, 0);
        else begin
          check("final_ba", cur_ba, exp_ba);
          check("final_wc", cur_wc, exp_wc);
          check("final_nxm", nxm, exp_nxm);
          check("busy_at_done", busy, 0);
          check("model_left", exp_q.size() + expw_q.size(), 0);
          model_active = 1'b0;
        end
        done_cnt++;
      end
      pm = bus.msyn_out_h;
      pbus = nowbus;
    end
  end

  task automatic kick(input logic dir, input logic [17:0] ba, input logic [15:0] wc);
    @(posedge CLOCK); #1;
    start = 1'b1; dir_write = dir; start_ba = ba; start_wc = wc;
    @(posedge CLOCK); #1;
    start = 1'b0;
  endtask

  task automatic run_xfer(input logic dir, input logic [17:0] ba, input logic [15:0] wc,
                          input bit restart);
    int base;
    base = done_cnt;
    seen_a.delete();
    plan(dir, ba, wc);
    kick(dir, ba, wc);
    check("busy_after_start", busy, wc != 16'd0);
    if (restart) begin
      repeat (5) @(posedge CLOCK);
      kick(~dir, 18'o070000, 16'd9);
    end
    for (int n = 0; n < 20000 && done_cnt == base; n++) @(negedge CLOCK);
    @(negedge CLOCK);
    check("done_pulses", done_cnt - base, 1);
  endtask

  initial begin : stim
    int base, np;
    bus.init_in_h = 1'b0;
    for (int i = 0; i < 256; i++) bsrc[i] = 16'(i * 3 + 16'h100);
    #1;
    check("reset_status", {busy, done, nxm, cur_ba, cur_wc, buf_addr, buf_wdata, buf_we}, 0);
    check("reset_bus", {bus.npr_out_h, bus.sack_out_h, bus.bbsy_out_h, bus.msyn_out_h,
                        bus.a_out_h, bus.c_out_h, bus.d_out_h}, 0);
    repeat (3) @(posedge CLOCK);
    #1 RESET_N = 1'b1;

    // DATO of three words, with a second start ignored mid-transfer
    bsrc[0] = 16'd1; bsrc[1] = 16'd2; bsrc[2] = 16'd3;
    run_xfer(1'b0, 18'o001000, 16'd3, 1'b1);
    check("t1_cur_ba", cur_ba, 18'o001006);
    check("t1_cur_wc", cur_wc, 0);
    check("t1_nxm", nxm, 0);
    check("t1_addr2", (seen_a.size() > 2) ? seen_a[2] : 18'h3ffff, 18'o001004);

    // DATI of two words; 654321 does not fit 16 bits, its low 16 bits are used
    rmem[18'o002000] = 16'o123456;
    rmem[18'o002002] = 16'o054321;
    run_xfer(1'b1, 18'o002000, 16'd2, 1'b0);
    check("t2_buf0", bdst[0], 16'o123456);
    check("t2_buf1", bdst[1], 16'o054321);

    // No SSYN: NXM on the first word
    dead_addr = 18'o760000;
    run_xfer(1'b0, 18'o760000, 16'd5, 1'b0);
    check("t3_cur_ba", cur_ba, 18'o760000);
    check("t3_cur_wc", cur_wc, 5);
    check("t3_nxm", nxm, 1);
    check("t3_bbsy", bus.bbsy_out_h, 0);
    dead_addr = 18'h3ffff;

    // Address wrap; bit 0 of the start address is dropped
    run_xfer(1'b0, 18'o777777, 16'd2, 1'b0);
    check("t4_wrap_addr", (seen_a.size() > 1) ? seen_a[1] : 18'h3ffff, 0);
    check("t4_cur_ba", cur_ba, 18'o000002);
    check("t4_nxm_cleared", nxm, 0);

    // INIT while MSYN is high
    base = done_cnt;
    kick(1'b0, 18'o003000, 16'd4);
    for (int n = 0; n < 200 && !bus.msyn_out_h; n++) @(negedge CLOCK);
    check("t5_msyn_before_init", bus.msyn_out_h, 1);
    @(posedge CLOCK); #1 bus.init_in_h = 1'b1;
    @(posedge CLOCK); #1 bus.init_in_h = 1'b0;
    check("t5_init_bus", {bus.npr_out_h, bus.sack_out_h, bus.bbsy_out_h, bus.msyn_out_h,
                          bus.a_out_h, bus.c_out_h, bus.d_out_h}, 0);
    check("t5_init_status", {busy, done, cur_ba}, 0);
    repeat (40) @(posedge CLOCK);
    #1 check("t5_no_done", done_cnt - base, 0);

    // RESET_N low while requesting
    grant_en = 1'b0;
    kick(1'b0, 18'o004000, 16'd1);
    for (int n = 0; n < 50 && !bus.npr_out_h; n++) @(negedge CLOCK);
    check("t5_npr_before_reset", bus.npr_out_h, 1);
    @(negedge CLOCK);
    RESET_N = 1'b0;
    #1;
    check("t5_reset_bus", {bus.npr_out_h, bus.sack_out_h, bus.bbsy_out_h, bus.msyn_out_h,
                           bus.a_out_h, bus.c_out_h, bus.d_out_h}, 0);
    check("t5_reset_status", {busy, done, nxm, cur_ba, cur_wc}, 0);
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    grant_en = 1'b1;

    // Zero word count, with start held into the done cycle
    base = done_cnt;
    np = npr_cnt;
    plan(1'b0, 18'o005000, 16'd0);
    @(posedge CLOCK); #1;
    start = 1'b1; dir_write = 1'b0; start_ba = 18'o005000; start_wc = 16'd0;
    @(posedge CLOCK); #1;
    check("t6_done_next_cycle", done, 1);
    start_ba = 18'o006000; start_wc = 16'd7;
    @(posedge CLOCK); #1;
    start = 1'b0;
    check("t6_done_single", done, 0);
    check("t6_busy", busy, 0);
    repeat (20) @(posedge CLOCK);
    #1;
    check("t6_no_npr", npr_cnt - np, 0);
    check("t6_done_count", done_cnt - base, 1);
    check("t6_cur_ba", cur_ba, 18'o005000);
    check("t6_cur_wc", cur_wc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run still active at %0t, expected summary earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
